// File: rtl/ac97_pkg.sv
// Shared definitions for the AC'97 register command scheduler: slot and TAG
// field positions, scheduler states and the power-up init ROM.
package ac97_pkg;

  localparam int SLOT_W       = 20;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 16;

  localparam int SLOT_RW_BIT  = 19;
  localparam int SLOT_ADDR_HI = 18;
  localparam int SLOT_ADDR_LO = 12;
  localparam int SLOT_DATA_HI = 19;
  localparam int SLOT_DATA_LO = 4;

  localparam int TAG_READY    = 15;
  localparam int TAG_SLOT1    = 14;
  localparam int TAG_SLOT2    = 13;

  typedef enum logic [2:0] {
    ST_WAIT_READY,
    ST_INIT_WR,
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } init_entry_t;

  localparam int INIT_LEN = 4;

  // Codec power-up writes: reset master/headphone volume, set PCM-out gain.
  function automatic init_entry_t init_rom(input logic [1:0] idx);
    init_entry_t e;
    case (idx)
      2'd0:    e = '{addr: 7'h02, data: 16'h0000};
      2'd1:    e = '{addr: 7'h04, data: 16'h0000};
      2'd2:    e = '{addr: 7'h18, data: 16'h0808};
      default: e = '{addr: 7'h1A, data: 16'h0000};
    endcase
    return e;
  endfunction

  function automatic logic [SLOT_W-1:0] addr_slot(input logic rd,
                                                  input logic [ADDR_W-1:0] addr);
    return {rd, addr, 12'h000};
  endfunction

  function automatic logic [SLOT_W-1:0] data_slot(input logic [DATA_W-1:0] data);
    return {data, 4'h0};
  endfunction

endpackage

// File: rtl/ac97_rr_arb.sv
// Two-way round-robin arbiter; the favoured requester flips away from the
// winner whenever a grant is taken (update asserted with a request present).
module ac97_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic prio_reg;

  always_comb begin
    grant_id = 1'b0;
    if (req[0] && req[1]) begin
      grant_id = prio_reg;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (update && (req != 2'b00)) begin
      prio_reg <= ~grant_id;
    end
  end

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC'97 codec register command scheduler: runs the init writes after codec
// ready, then arbitrates two requesters onto slots 1/2 and matches read replies.
module ac97_cmd_sched
  import ac97_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic              ac97_bitclk,
  input  logic              ac97_reset_b,
  input  logic              ac97_strobe,
  input  logic [15:0]       ac97_in_tag,
  input  logic [SLOT_W-1:0] ac97_in_slot1,
  input  logic [SLOT_W-1:0] ac97_in_slot2,
  output logic [SLOT_W-1:0] ac97_out_slot1,
  output logic              ac97_out_slot1_valid,
  output logic [SLOT_W-1:0] ac97_out_slot2,
  output logic              ac97_out_slot2_valid,
  input  logic              cmd0_valid,
  output logic              cmd0_ready,
  input  logic              cmd0_write,
  input  logic [ADDR_W-1:0] cmd0_addr,
  input  logic [DATA_W-1:0] cmd0_data,
  input  logic              cmd1_valid,
  output logic              cmd1_ready,
  input  logic              cmd1_write,
  input  logic [ADDR_W-1:0] cmd1_addr,
  input  logic [DATA_W-1:0] cmd1_data,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              init_done
);

  state_t            state_reg, state_next;
  logic [2:0]        init_idx_reg, init_idx_next;
  logic [3:0]        frame_cnt_reg, frame_cnt_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              cur_id_reg, cur_id_next;
  logic [SLOT_W-1:0] slot1_reg, slot1_next;
  logic [SLOT_W-1:0] slot2_reg, slot2_next;
  logic              slot1_valid_reg, slot1_valid_next;
  logic              slot2_valid_reg, slot2_valid_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_id_reg, rsp_id_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic              init_done_reg, init_done_next;

  logic [1:0]        grant;
  logic              grant_id;
  logic              arb_update;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              rd_match;
  init_entry_t       rom_entry;

  logic              unused_in_bits;
  assign unused_in_bits = ^{ac97_in_tag[12:0], ac97_in_slot1[19], ac97_in_slot1[11:0],
                            ac97_in_slot2[3:0]};

  // Grants are only taken on the IDLE strobe; the arbiter advances with them.
  assign arb_update = ac97_strobe && (state_reg == ST_IDLE);

  ac97_rr_arb u_arb (
    .clk      (ac97_bitclk),
    .rst_n    (ac97_reset_b),
    .req      ({cmd1_valid, cmd0_valid}),
    .update   (arb_update),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign cmd0_ready = arb_update && grant[0];
  assign cmd1_ready = arb_update && grant[1];

  assign sel_write = grant_id ? cmd1_write : cmd0_write;
  assign sel_addr  = grant_id ? cmd1_addr  : cmd0_addr;
  assign sel_data  = grant_id ? cmd1_data  : cmd0_data;

  assign rd_match = ac97_in_tag[TAG_SLOT1] &&
                    (ac97_in_slot1[SLOT_ADDR_HI:SLOT_ADDR_LO] == rd_addr_reg);

  always_comb begin
    state_next       = state_reg;
    init_idx_next    = init_idx_reg;
    frame_cnt_next   = frame_cnt_reg;
    rd_addr_next     = rd_addr_reg;
    cur_id_next      = cur_id_reg;
    slot1_next       = slot1_reg;
    slot2_next       = slot2_reg;
    slot1_valid_next = slot1_valid_reg;
    slot2_valid_next = slot2_valid_reg;
    rsp_valid_next   = 1'b0;
    rsp_id_next      = rsp_id_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_timeout_next = rsp_timeout_reg;
    init_done_next   = init_done_reg;
    rom_entry        = init_rom(init_idx_reg[1:0]);

    if (ac97_strobe) begin
      case (state_reg)
        ST_WAIT_READY: begin
          if (ac97_in_tag[TAG_READY]) begin
            state_next    = ST_INIT_WR;
            init_idx_next = 3'd0;
          end
        end

        ST_INIT_WR: begin
          if (init_idx_reg == 3'(INIT_LEN)) begin
            slot1_next       = '0;
            slot2_next       = '0;
            slot1_valid_next = 1'b0;
            slot2_valid_next = 1'b0;
            init_done_next   = 1'b1;
            state_next       = ST_IDLE;
          end else begin
            slot1_next       = addr_slot(1'b0, rom_entry.addr);
            slot2_next       = data_slot(rom_entry.data);
            slot1_valid_next = 1'b1;
            slot2_valid_next = 1'b1;
            init_idx_next    = init_idx_reg + 3'd1;
          end
        end

        ST_IDLE: begin
          if (cmd0_valid || cmd1_valid) begin
            cur_id_next      = grant_id;
            slot1_valid_next = 1'b1;
            if (sel_write) begin
              slot1_next       = addr_slot(1'b0, sel_addr);
              slot2_next       = data_slot(sel_data);
              slot2_valid_next = 1'b1;
              state_next       = ST_WR_ISSUE;
            end else begin
              slot1_next       = addr_slot(1'b1, sel_addr);
              slot2_next       = '0;
              slot2_valid_next = 1'b0;
              rd_addr_next     = sel_addr;
              frame_cnt_next   = 4'd0;
              state_next       = ST_RD_WAIT;
            end
          end
        end

        ST_WR_ISSUE: begin
          slot1_next       = '0;
          slot2_next       = '0;
          slot1_valid_next = 1'b0;
          slot2_valid_next = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_id_next      = cur_id_reg;
          rsp_data_next    = '0;
          rsp_timeout_next = 1'b0;
          state_next       = ST_IDLE;
        end

        ST_RD_WAIT: begin
          slot1_next       = '0;
          slot2_next       = '0;
          slot1_valid_next = 1'b0;
          slot2_valid_next = 1'b0;
          // A match on the final frame still wins over the timeout.
          if (rd_match) begin
            rsp_valid_next   = 1'b1;
            rsp_id_next      = cur_id_reg;
            rsp_data_next    = ac97_in_slot2[SLOT_DATA_HI:SLOT_DATA_LO];
            rsp_timeout_next = 1'b0;
            state_next       = ST_IDLE;
          end else if (frame_cnt_reg == 4'(TIMEOUT_FRAMES - 1)) begin
            rsp_valid_next   = 1'b1;
            rsp_id_next      = cur_id_reg;
            rsp_data_next    = 16'hFFFF;
            rsp_timeout_next = 1'b1;
            state_next       = ST_IDLE;
          end else begin
            frame_cnt_next = frame_cnt_reg + 4'd1;
          end
        end

        default: state_next = ST_WAIT_READY;
      endcase
    end
  end

  always_ff @(posedge ac97_bitclk or negedge ac97_reset_b) begin
    if (!ac97_reset_b) begin
      state_reg       <= ST_WAIT_READY;
      init_idx_reg    <= '0;
      frame_cnt_reg   <= '0;
      rd_addr_reg     <= '0;
      cur_id_reg      <= 1'b0;
      slot1_reg       <= '0;
      slot2_reg       <= '0;
      slot1_valid_reg <= 1'b0;
      slot2_valid_reg <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
      init_done_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      init_idx_reg    <= init_idx_next;
      frame_cnt_reg   <= frame_cnt_next;
      rd_addr_reg     <= rd_addr_next;
      cur_id_reg      <= cur_id_next;
      slot1_reg       <= slot1_next;
      slot2_reg       <= slot2_next;
      slot1_valid_reg <= slot1_valid_next;
      slot2_valid_reg <= slot2_valid_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
      init_done_reg   <= init_done_next;
    end
  end

  assign ac97_out_slot1       = slot1_reg;
  assign ac97_out_slot2       = slot2_reg;
  assign ac97_out_slot1_valid = slot1_valid_reg;
  assign ac97_out_slot2_valid = slot2_valid_reg;
  assign rsp_valid            = rsp_valid_reg;
  assign rsp_id               = rsp_id_reg;
  assign rsp_data             = rsp_data_reg;
  assign rsp_timeout          = rsp_timeout_reg;
  assign init_done            = init_done_reg;

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Self-checking bench for ac97_cmd_sched: table-driven init and command
// vectors with a response scoreboard, plus fairness and mid-read reset runs.
module tb_ac97_cmd_sched;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        strobe = 1'b0;
  logic [15:0] in_tag = '0;
  logic [19:0] in_slot1 = '0, in_slot2 = '0;
  logic [19:0] out_slot1, out_slot2;
  logic        out_v1, out_v2;
  logic        cmd0_valid = 1'b0, cmd0_ready, cmd0_write = 1'b0;
  logic [6:0]  cmd0_addr = '0;
  logic [15:0] cmd0_data = '0;
  logic        cmd1_valid = 1'b0, cmd1_ready, cmd1_write = 1'b0;
  logic [6:0]  cmd1_addr = '0;
  logic [15:0] cmd1_data = '0;
  logic        rsp_valid, rsp_id, rsp_timeout, init_done;
  logic [15:0] rsp_data;

  always #5 clk = ~clk;

  ac97_cmd_sched #(.TIMEOUT_FRAMES(4)) dut (
    .ac97_bitclk(clk), .ac97_reset_b(reset_b), .ac97_strobe(strobe),
    .ac97_in_tag(in_tag), .ac97_in_slot1(in_slot1), .ac97_in_slot2(in_slot2),
    .ac97_out_slot1(out_slot1), .ac97_out_slot1_valid(out_v1),
    .ac97_out_slot2(out_slot2), .ac97_out_slot2_valid(out_v2),
    .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_write(cmd0_write),
    .cmd0_addr(cmd0_addr), .cmd0_data(cmd0_data),
    .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_write(cmd1_write),
    .cmd1_addr(cmd1_addr), .cmd1_data(cmd1_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .init_done(init_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic id; logic [15:0] data; logic timeout; } rsp_t;
  rsp_t sb_q[$];

  typedef struct { logic [19:0] s1; logic [19:0] s2; } init_vec_t;
  typedef struct {
    logic id; logic write; logic [6:0] addr; logic [15:0] data;
    int rsp_frame; logic decoy; logic [19:0] rsp_slot2;
    logic [19:0] exp_s1; logic [19:0] exp_s2; logic exp_v2;
    int done_frame; logic [15:0] exp_rsp; logic exp_to;
  } cmd_vec_t;

  init_vec_t init_tab[4];
  cmd_vec_t  cmd_tab[8];

  logic seen_r0, seen_r1;
  logic rsp_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response pulse pops one expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      check("rsp_one_cycle", {31'b0, rsp_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
        check("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.timeout});
        $display("rsp id=%0d data=0x%04h timeout=%0d", rsp_id, rsp_data, rsp_timeout);
      end
    end
    rsp_prev = rsp_valid;
  end

  // One frame: idle gap, one strobe cycle, return just after the strobe edge.
  task automatic frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2);
    repeat (4) @(negedge clk);
    in_tag = tag; in_slot1 = s1; in_slot2 = s2; strobe = 1'b1;
    #1;
    seen_r0 = cmd0_ready;
    seen_r1 = cmd1_ready;
    check("ready_exclusive", {31'b0, seen_r0 & seen_r1}, 32'd0);
    @(negedge clk);
    strobe = 1'b0; in_tag = '0; in_slot1 = '0; in_slot2 = '0;
  endtask

  task automatic set_cmd(input logic id, input logic v, input logic w,
                         input logic [6:0] a, input logic [15:0] d);
    if (!id) begin
      cmd0_valid = v; cmd0_write = w; cmd0_addr = a; cmd0_data = d;
    end else begin
      cmd1_valid = v; cmd1_write = w; cmd1_addr = a; cmd1_data = d;
    end
  endtask

  initial begin
    logic       fav;
    logic       gid;
    logic [15:0] tag;
    logic [19:0] s1, s2;

    init_tab[0] = '{20'h02000, 20'h00000};
    init_tab[1] = '{20'h04000, 20'h00000};
    init_tab[2] = '{20'h18000, 20'h08080};
    init_tab[3] = '{20'h1A000, 20'h00000};

    //               id    wr    addr   data      rf dec  rsp_s2     exp_s1     exp_s2     v2   done rsp       to
    cmd_tab[0] = '{1'b0, 1'b1, 7'h02, 16'h8000, 0, 1'b0, 20'h00000, 20'h02000, 20'h80000, 1'b1, 1, 16'h0000, 1'b0};
    cmd_tab[1] = '{1'b1, 1'b0, 7'h7C, 16'h0000, 2, 1'b0, 20'h41440, 20'hFC000, 20'h00000, 1'b0, 2, 16'h4144, 1'b0};
    cmd_tab[2] = '{1'b0, 1'b0, 7'h26, 16'h0000, 0, 1'b0, 20'h00000, 20'hA6000, 20'h00000, 1'b0, 4, 16'hFFFF, 1'b1};
    cmd_tab[3] = '{1'b1, 1'b0, 7'h1C, 16'h0000, 3, 1'b1, 20'hABCD0, 20'h9C000, 20'h00000, 1'b0, 3, 16'hABCD, 1'b0};
    cmd_tab[4] = '{1'b0, 1'b0, 7'h28, 16'h0000, 4, 1'b0, 20'h13570, 20'hA8000, 20'h00000, 1'b0, 4, 16'h1357, 1'b0};
    cmd_tab[5] = '{1'b1, 1'b1, 7'h18, 16'h1234, 0, 1'b0, 20'h00000, 20'h18000, 20'h12340, 1'b1, 1, 16'h0000, 1'b0};
    cmd_tab[6] = '{1'b0, 1'b0, 7'h2C, 16'h0000, 1, 1'b0, 20'h00010, 20'hAC000, 20'h00000, 1'b0, 1, 16'h0001, 1'b0};
    cmd_tab[7] = '{1'b1, 1'b1, 7'h26, 16'hBEEF, 0, 1'b0, 20'h00000, 20'h26000, 20'hBEEF0, 1'b1, 1, 16'h0000, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_slot1", {12'b0, out_slot1}, 32'd0);
    check("reset_slot2", {12'b0, out_slot2}, 32'd0);
    check("reset_valids", {30'b0, out_v1, out_v2}, 32'd0);
    check("reset_rsp", {30'b0, rsp_valid, rsp_timeout}, 32'd0);
    check("reset_init_done", {31'b0, init_done}, 32'd0);
    reset_b = 1'b1;

    // Codec not ready: nothing may be driven.
    for (int i = 0; i < 5; i++) begin
      frame(16'h0000, '0, '0);
      check("pre_ready_quiet", {30'b0, out_v1, init_done}, 32'd0);
    end
    frame(16'h8000, '0, '0);
    check("ready_strobe_quiet", {31'b0, out_v1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      frame(16'h8000, '0, '0);
      $display("init %0d slot1=0x%05h slot2=0x%05h", i, out_slot1, out_slot2);
      check("init_slot1", {12'b0, out_slot1}, {12'b0, init_tab[i].s1});
      check("init_slot2", {12'b0, out_slot2}, {12'b0, init_tab[i].s2});
      check("init_valids", {30'b0, out_v1, out_v2}, 32'd3);
      check("init_not_done", {31'b0, init_done}, 32'd0);
    end
    frame(16'h8000, '0, '0);
    check("init_done_set", {31'b0, init_done}, 32'd1);
    check("init_slots_clear", {30'b0, out_v1, out_v2}, 32'd0);

    // Command vectors; codec-ready dropped on some frames must be ignored.
    for (int v = 0; v < 8; v++) begin
      cmd_vec_t c;
      c = cmd_tab[v];
      set_cmd(c.id, 1'b1, c.write, c.addr, c.data);
      frame((v % 2 == 0) ? 16'h8000 : 16'h0000, '0, '0);
      set_cmd(c.id, 1'b0, 1'b0, 7'h00, 16'h0000);
      check("ready_mine", {31'b0, c.id ? seen_r1 : seen_r0}, 32'd1);
      check("ready_other", {31'b0, c.id ? seen_r0 : seen_r1}, 32'd0);
      if ((c.id ? seen_r1 : seen_r0) === 1'b1) sb_q.push_back('{c.id, c.exp_rsp, c.exp_to});
      $display("cmd %0d id=%0d slot1=0x%05h slot2=0x%05h v=%0d%0d", v, c.id, out_slot1,
               out_slot2, out_v1, out_v2);
      check("cmd_slot1", {12'b0, out_slot1}, {12'b0, c.exp_s1});
      check("cmd_slot2", {12'b0, out_slot2}, {12'b0, c.exp_s2});
      check("cmd_valids", {30'b0, out_v1, out_v2}, {30'b0, 1'b1, c.exp_v2});
      for (int k = 1; k <= c.done_frame; k++) begin
        tag = 16'h8000; s1 = '0; s2 = '0;
        if (k == c.rsp_frame) begin
          tag = 16'hC000; s1 = {1'b0, c.addr, 12'h000}; s2 = c.rsp_slot2;
        end else if (c.decoy && k == 1) begin
          tag = 16'hC000; s1 = {1'b0, c.addr ^ 7'h01, 12'h000}; s2 = 20'h55550;
        end
        frame(tag, s1, s2);
        check("rsp_timing", {31'b0, rsp_valid}, {31'b0, k == c.done_frame});
        if (k == 1) check("slots_cleared", {30'b0, out_v1, out_v2}, 32'd0);
      end
    end

    // Both requesters hold writes: grants alternate, never on completion strobes.
    fav = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b1, 7'h02, 16'h0101);
    set_cmd(1'b1, 1'b1, 1'b1, 7'h04, 16'h0202);
    for (int n = 0; n < 4; n++) begin
      frame(16'h8000, '0, '0);
      gid = seen_r1;
      $display("rr grant %0d: ready0=%0d ready1=%0d", n, seen_r0, seen_r1);
      check("rr_one_grant", {31'b0, seen_r0 | seen_r1}, 32'd1);
      check("rr_order", {31'b0, gid}, {31'b0, fav});
      check("rr_slot1", {12'b0, out_slot1}, fav ? 32'h04000 : 32'h02000);
      sb_q.push_back('{gid, 16'h0000, 1'b0});
      fav = ~gid;
      frame(16'h8000, '0, '0);
      check("no_accept_on_done", {30'b0, seen_r0, seen_r1}, 32'd0);
      check("rr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    end
    set_cmd(1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
    set_cmd(1'b1, 1'b0, 1'b0, 7'h00, 16'h0000);
    frame(16'h8000, '0, '0);

    // Reset while a read is outstanding.
    set_cmd(1'b0, 1'b1, 1'b0, 7'h30, 16'h0000);
    frame(16'h8000, '0, '0);
    set_cmd(1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
    check("rst_rd_accept", {31'b0, seen_r0}, 32'd1);
    check("rst_rd_slot1", {12'b0, out_slot1}, 32'hB0000);
    frame(16'h8000, '0, '0);
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("midrst_slot1", {12'b0, out_slot1}, 32'd0);
    check("midrst_outs", {26'b0, out_v1, out_v2, rsp_valid, rsp_timeout, init_done,
                          cmd0_ready}, 32'd0);
    check("midrst_rsp_data", {16'b0, rsp_data}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame(16'h0000, '0, '0);
      check("rerun_quiet", {29'b0, out_v1, rsp_valid, init_done}, 32'd0);
    end
    frame(16'h8000, '0, '0);
    for (int i = 0; i < 4; i++) begin
      frame(16'h0000, '0, '0);
      check("rerun_slot1", {12'b0, out_slot1}, {12'b0, init_tab[i].s1});
    end
    frame(16'h0000, '0, '0);
    check("rerun_init_done", {31'b0, init_done}, 32'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_sched.md
# ac97_cmd_sched

Codec register command scheduler for the AC'97 link. It runs the power-up register init sequence once the codec reports ready. After that it round-robin arbitrates register read/write commands from two requesters and drives them onto output slots 1/2 one frame at a time. It matches read responses in input slots 1/2, with a per-command timeout. It sits between the frame-level link (`ACLink`) and any control logic that needs codec register access, replacing the constant slot1/slot2 tie-offs.

## Interface
- `TIMEOUT_FRAMES`, 4: frames (strobes) to wait for a read response before timing out; legal range 2..15.
- `ac97_bitclk`  in  1  AC'97 bit clock; all logic on its rising edge.
- `ac97_reset_b`  in  1  asynchronous, active-low reset.
- `ac97_strobe`  in  1  one-cycle frame strobe from ACLink (bit 0 on bus); latched input fields are valid in this cycle.
- `ac97_in_tag`  in  16  latched input TAG: [15] codec ready, [14] slot1 valid, [13] slot2 valid.
- `ac97_in_slot1`  in  20  latched status address: [18:12] register index echo.
- `ac97_in_slot2`  in  20  latched status data: [19:4] register data.
- `ac97_out_slot1`, `ac97_out_slot1_valid`  out  20, 1  command address slot: [19] 1=read/0=write, [18:12] index, [11:0] zero.
- `ac97_out_slot2`, `ac97_out_slot2_valid`  out  20, 1  command data slot: [19:4] write data, [3:0] zero.
- `cmd0_valid`/`cmd1_valid`  in  1  requester has a command.
- `cmd0_ready`/`cmd1_ready`  out  1  command accepted this cycle.
- `cmdN_write`  in  1  1=write, 0=read.
- `cmdN_addr`  in  7  register index.
- `cmdN_data`  in  16  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_id`  out  1  requester that owns the completed command.
- `rsp_data`  out  16  read data (0x0000 for writes, 0xFFFF on timeout).
- `rsp_timeout`  out  1  read got no matching response.
- `init_done`  out  1  init sequence complete; sticky until reset.

## Operation
- **Reset values.** All outputs are 0. The round-robin pointer favours cmd0. The state machine is in WAIT_READY.
- **State changes.** States: WAIT_READY, INIT_WR, IDLE, WR_ISSUE, RD_WAIT. All state and output changes happen only in cycles with `ac97_strobe`=1. Slot outputs are registered there and held constant for the whole frame.
- **WAIT_READY.** On a strobe with `ac97_in_tag[15]`=1, go to INIT_WR with index 0. Waits indefinitely otherwise.
- **INIT_WR.** Each strobe drives one init write with both valid bits set: 0x02←0x0000, 0x04←0x0000, 0x18←0x0808, 0x1A←0x0000. On the strobe after the 4th write, clear the slots, set `init_done`, and go to IDLE. No `rsp_valid` is generated for init writes.
- **IDLE.** On a strobe with any `cmdN_valid`, grant one requester:
  - The other requester is granted if it was not the last one granted; a lone requester always wins.
  - Assert `cmdN_ready` for that single cycle, register the slots, and toggle the pointer.
  - Write: both valid bits 1 → WR_ISSUE.
  - Read: slot1_valid=1, slot2_valid=0, slot2=0 → RD_WAIT with frame counter 0.
- **WR_ISSUE.** At the next strobe, clear the slots and pulse `rsp_valid` with `rsp_data`=0 and `rsp_timeout`=0. Go to IDLE.
- **RD_WAIT.** The slots are cleared at the first strobe. Each strobe checks for a match: `ac97_in_tag[14]` && `ac97_in_slot1[18:12]`==addr.
  - Match: pulse `rsp_valid` with `rsp_data`=`ac97_in_slot2[19:4]` → IDLE.
  - No match: increment the counter. When the counter reaches `TIMEOUT_FRAMES`, pulse `rsp_valid` with `rsp_timeout`=1 and `rsp_data`=0xFFFF → IDLE.
- **No accept on completion strobe.** The strobe that completes a command never accepts a new one; the earliest next accept is the following strobe.
- **Codec ready after init.** Codec-ready deassertion after `init_done` is ignored.
- **Reset mid-command.** The command is abandoned, no response is issued, and init reruns.

## Timing
- Command accept → slots valid: 1 cycle (registered on the strobe edge; ACLink transmits slot1 starting at bit 16).
- Write: accept strobe N → `rsp_valid` at strobe N+1.
- Read:
  - Earliest response: strobe N+1 (matching is enabled from N+1).
  - Typical response (AD1981B): strobe N+2.
  - Timeout: strobe N+`TIMEOUT_FRAMES`.
- Minimum command spacing: 2 frames for a write.
- `cmdN_ready`, `rsp_valid`: combinational or registered, but exactly one cycle wide, coincident with or immediately after the strobe.

## Structure
- **Package `ac97_pkg`:**
  - slot field positions (RW bit, address field, data field);
  - TAG bit indices (ready, slot1, slot2);
  - the state enum;
  - the init ROM: 4 entries of {addr, data}, plus its length constant.
- **Sub-module `ac97_rr_arb`:** 2-way round-robin arbiter with an update-on-grant input.

## Test plan
- **Init gating and sequence.** Tag ready=0 for 5 strobes, then 1 → no slot activity before ready. Then 4 frames carrying slot1=0x02000/0x04000/0x18000/0x1A000 and slot2=0x00000/0x00000/0x08080/0x00000; `init_done`=1 at the 5th strobe.
- **Write completion.** cmd0 write 0x02←0x8000 → slot1=0x02000, slot2=0x80000, both valid; `rsp_valid`, `rsp_id`=0, `rsp_timeout`=0 at the next strobe.
- **Read match.** cmd1 read 0x7C; codec returns tag[14]=1, slot1=0x7C000, slot2=0x41440 two strobes later → `rsp_data`=0x4144, `rsp_id`=1.
- **Read timeout.** Read 0x26 with no matching response → `rsp_timeout`=1, `rsp_data`=0xFFFF at strobe N+4.
- **Round-robin fairness.** Both requesters hold valid for 4 commands → grants alternate 0,1,0,1; never two accepts in one cycle.
- **Reset mid-read.** Assert `ac97_reset_b`=0 while in RD_WAIT → all outputs 0 immediately; no `rsp_valid`; init reruns after the next ready.
